// File: rtl/csr_arbiter_pkg.sv
// Shared types for the CSR port arbiter: op codes, FSM states, grant ids.
package csr_arbiter_pkg;

    localparam int CSR_AW = 12;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_ACK
    } state_e;

    typedef enum logic {
        GNT_CORE = 1'b0,
        GNT_DBG  = 1'b1
    } gnt_e;

    // SET/CLEAR with an all-zero mask cannot change the register, so skip the write
    function automatic logic op_writes(op_e op, logic mask_nz);
        return (op == OP_WRITE) || ((op != OP_READ) && mask_nz);
    endfunction

endpackage

// File: rtl/csr_arbiter_if.sv
// One requester's CSR operation handshake: held req/op/addr/wdata, ack pulse, old value.
interface csr_arbiter_if #(
    parameter int DATA_W = 32
);
    import csr_arbiter_pkg::*;

    logic              req;
    op_e               op;
    logic [CSR_AW-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, op, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, op, addr, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/csr_arbiter_rr_arb.sv
// Two-way round-robin grant; last grant resets to debug so the core wins the first tie.
module csr_arbiter_rr_arb
    import csr_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_core,
    input  logic req_dbg,
    input  logic take,
    output gnt_e gnt,
    output logic valid
);

    gnt_e last_q;

    always_comb begin
        valid = req_core | req_dbg;
        gnt   = GNT_DBG;
        if (req_core && req_dbg) begin
            gnt = (last_q == GNT_DBG) ? GNT_CORE : GNT_DBG;
        end else if (req_core) begin
            gnt = GNT_CORE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GNT_DBG;
        end else if (take && valid) begin
            last_q <= gnt;
        end
    end

endmodule

// File: rtl/csr_arbiter.sv
// Shares the csr_reg port between core and debug: read, optional write, then ack.
module csr_arbiter
    import csr_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    csr_arbiter_if.slave      core,
    csr_arbiter_if.slave      dbg,
    output logic [ADDR_W-1:0] csr_raddr,
    input  logic [DATA_W-1:0] csr_rdata,
    output logic              csr_we,
    output logic [ADDR_W-1:0] csr_waddr,
    output logic [DATA_W-1:0] csr_wdata,
    output logic              busy
);

    state_e            state;
    gnt_e              id_q;
    op_e               op_q;
    logic [CSR_AW-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] old_q;
    logic [DATA_W-1:0] new_val;
    logic [DATA_W-1:0] ret;
    logic              do_write;
    logic              deliver;
    gnt_e              gnt;
    logic              gnt_valid;

    csr_arbiter_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_core (core.req),
        .req_dbg  (dbg.req),
        .take     (state == S_IDLE),
        .gnt      (gnt),
        .valid    (gnt_valid)
    );

    assign csr_raddr = {{(ADDR_W-CSR_AW){1'b0}}, addr_q};
    assign csr_waddr = {{(ADDR_W-CSR_AW){1'b0}}, addr_q};

    assign do_write = op_writes(op_q, |wdata_q);

    always_comb begin
        new_val = wdata_q;
        unique case (op_q)
            OP_SET:   new_val = csr_rdata | wdata_q;
            OP_CLEAR: new_val = csr_rdata & ~wdata_q;
            default:  ;
        endcase
    end

    // Ack rises on the edge leaving READ (no write) or WRITE; rdata loads on that edge
    assign deliver = ((state == S_READ) && !do_write) || (state == S_WRITE);
    assign ret     = (state == S_READ) ? csr_rdata : old_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            id_q       <= GNT_CORE;
            op_q       <= OP_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            old_q      <= '0;
            csr_we     <= 1'b0;
            csr_wdata  <= '0;
            busy       <= 1'b0;
            core.ack   <= 1'b0;
            core.rdata <= '0;
            dbg.ack    <= 1'b0;
            dbg.rdata  <= '0;
        end else begin
            core.ack <= 1'b0;
            dbg.ack  <= 1'b0;
            csr_we   <= 1'b0;
            if (deliver) begin
                if (id_q == GNT_CORE) begin
                    core.ack   <= 1'b1;
                    core.rdata <= ret;
                end else begin
                    dbg.ack   <= 1'b1;
                    dbg.rdata <= ret;
                end
            end
            unique case (state)
                S_IDLE: begin
                    if (gnt_valid) begin
                        id_q    <= gnt;
                        op_q    <= (gnt == GNT_CORE) ? core.op : dbg.op;
                        addr_q  <= (gnt == GNT_CORE) ? core.addr : dbg.addr;
                        wdata_q <= (gnt == GNT_CORE) ? core.wdata : dbg.wdata;
                        busy    <= 1'b1;
                        state   <= S_READ;
                    end
                end
                S_READ: begin
                    old_q <= csr_rdata;
                    if (do_write) begin
                        csr_we    <= 1'b1;
                        csr_wdata <= new_val;
                        state     <= S_WRITE;
                    end else begin
                        state <= S_ACK;
                    end
                end
                S_WRITE: state <= S_ACK;
                S_ACK: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_arbiter.sv
// Bench for csr_arbiter: transaction-level model plus directed and random requesters.
module tb_csr_arbiter;
    import csr_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] csr_raddr, csr_waddr, csr_wdata, csr_rdata;
    logic        csr_we, busy;
    logic [31:0] cyc = 0;
    int          checks = 0;
    int          failures = 0;

    csr_arbiter_if core_if ();
    csr_arbiter_if dbg_if ();

    csr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .core      (core_if),
        .dbg       (dbg_if),
        .csr_raddr (csr_raddr),
        .csr_rdata (csr_rdata),
        .csr_we    (csr_we),
        .csr_waddr (csr_waddr),
        .csr_wdata (csr_wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // csr_reg stand-in: 0xC00 reads the cycle counter, everything else is memory
    logic [31:0] mem [0:4095];
    always @(posedge clk) if (csr_we) mem[csr_waddr[11:0]] <= csr_wdata;
    assign csr_rdata = (csr_raddr == 32'hC00) ? cyc : mem[csr_raddr[11:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: one op in flight, timed from its grant cycle
    bit          m_act = 0;
    int          m_g, m_ackc;
    bit          m_who, m_w;
    bit          m_last = 1;
    op_e         m_op;
    logic [11:0] m_addr;
    logic [31:0] m_wd, m_old;
    logic [31:0] m_lat = 0;
    logic [31:0] m_rd [2];
    logic [31:0] mmem [0:4095];
    int          ack_q[$];
    int          we_cnt = 0;
    int          overlap = 0;
    logic [31:0] last_wa = 0, last_wd = 0;

    always @(negedge clk) begin : cmp
        int          c;
        logic [31:0] nv;
        bit          e_busy, e_we, e_a0, e_a1, who;
        c = int'(cyc);
        if (m_act && c == m_g + 1) m_old = (m_addr == 12'hC00) ? cyc : mmem[m_addr];
        case (m_op)
            OP_WRITE: nv = m_wd;
            OP_SET:   nv = m_old | m_wd;
            OP_CLEAR: nv = m_old & ~m_wd;
            default:  nv = m_old;
        endcase
        if (m_act && c == m_ackc) m_rd[m_who] = m_old;
        e_busy = m_act && c > m_g;
        e_we   = m_act && m_w && c == m_g + 2;
        e_a0   = m_act && c == m_ackc && !m_who;
        e_a1   = m_act && c == m_ackc && m_who;
        chk("busy", 32'(busy), 32'(e_busy));
        chk("we", 32'(csr_we), 32'(e_we));
        chk("core_ack", 32'(core_if.ack), 32'(e_a0));
        chk("dbg_ack", 32'(dbg_if.ack), 32'(e_a1));
        chk("raddr", csr_raddr, m_lat);
        chk("waddr", csr_waddr, m_lat);
        chk("core_rdata", core_if.rdata, m_rd[0]);
        chk("dbg_rdata", dbg_if.rdata, m_rd[1]);
        if (e_we) begin
            chk("wdata", csr_wdata, nv);
            mmem[m_addr] = nv;
        end
        if (csr_we) begin
            we_cnt++;
            last_wa = csr_waddr;
            last_wd = csr_wdata;
        end
        if (core_if.ack) ack_q.push_back(0);
        if (dbg_if.ack) ack_q.push_back(1);
        if (core_if.ack && dbg_if.ack) overlap++;
        if (rst) begin
            m_act = 0;
            m_last = 1;
            m_lat = 0;
            m_rd[0] = 0;
            m_rd[1] = 0;
        end else if (m_act && c == m_ackc) begin
            m_act = 0;
        end else if (!m_act && (core_if.req || dbg_if.req)) begin
            who    = (core_if.req && dbg_if.req) ? !m_last : dbg_if.req;
            m_last = who;
            m_who  = who;
            m_act  = 1;
            m_g    = c;
            m_op   = who ? dbg_if.op : core_if.op;
            m_addr = who ? dbg_if.addr : core_if.addr;
            m_wd   = who ? dbg_if.wdata : core_if.wdata;
            m_w    = (m_op == OP_WRITE) || (m_op != OP_READ && m_wd != 0);
            m_ackc = c + (m_w ? 3 : 2);
            m_lat  = {20'b0, m_addr};
        end
    end

    // Called just after a rising edge; returns just after the edge following ack
    task automatic drive(input bit who, input op_e op, input logic [11:0] addr,
                         input logic [31:0] wd, output int lat,
                         output logic [31:0] rdv, output logic [31:0] rdcyc);
        bit got = 0;
        if (!who) begin
            core_if.req = 1; core_if.op = op; core_if.addr = addr; core_if.wdata = wd;
        end else begin
            dbg_if.req = 1; dbg_if.op = op; dbg_if.addr = addr; dbg_if.wdata = wd;
        end
        lat = 0; rdv = 0; rdcyc = 0;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            if (n == 2) rdcyc = cyc;
            if (who ? dbg_if.ack : core_if.ack) begin
                got = 1;
                lat = n;
                rdv = who ? dbg_if.rdata : core_if.rdata;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: requester %0d got no ack, required within 40 cycles", who);
        end
        @(posedge clk); #1;
    endtask

    task automatic drop(input bit who);
        if (!who) core_if.req = 0;
        else dbg_if.req = 0;
    endtask

    function automatic logic [11:0] pick_addr(input int i);
        case (i)
            0:       return 12'h300;
            1:       return 12'h301;
            2:       return 12'h340;
            default: return 12'hC00;
        endcase
    endfunction

    task automatic random_req(input bit who, input int nops);
        int          lat;
        logic [31:0] rdv, rdc, wd;
        for (int k = 0; k < nops; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                drop(who);
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            drive(who, op_e'($urandom_range(0, 3)), pick_addr($urandom_range(0, 3)),
                  wd, lat, rdv, rdc);
        end
        drop(who);
    endtask

    initial begin : main
        int          lat, w0;
        logic [31:0] rdv, rdc;
        for (int i = 0; i < 4096; i++) begin
            mem[i]  = 0;
            mmem[i] = 0;
        end
        m_rd[0] = 0;
        m_rd[1] = 0;
        core_if.req = 1; core_if.op = OP_READ; core_if.addr = 0; core_if.wdata = 0;
        dbg_if.req = 0;  dbg_if.op = OP_READ;  dbg_if.addr = 0;  dbg_if.wdata = 0;

        repeat (3) begin
            @(negedge clk);
            chk("rst_ack", 32'(core_if.ack), 0);
            chk("rst_we", 32'(csr_we), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_core_rdata", core_if.rdata, 0);
            chk("rst_dbg_rdata", dbg_if.rdata, 0);
        end
        @(posedge clk); #1;
        rst = 0;
        core_if.req = 0;
        @(posedge clk); #1;

        w0 = we_cnt;
        drive(0, OP_READ, 12'hC00, 0, lat, rdv, rdc);
        drop(0);
        chk("c00_latency", lat, 3);
        chk("c00_rdata", rdv, rdc);
        chk("c00_no_we", we_cnt - w0, 0);

        w0 = we_cnt;
        drive(1, OP_WRITE, 12'h300, 32'h88, lat, rdv, rdc);
        drop(1);
        chk("wr_latency", lat, 4);
        chk("wr_rdata", rdv, 0);
        chk("wr_we_cycles", we_cnt - w0, 1);
        chk("wr_waddr", last_wa, 32'h300);
        chk("wr_wdata", last_wd, 32'h88);

        w0 = we_cnt;
        drive(1, OP_SET, 12'h300, 32'h3, lat, rdv, rdc);
        drop(1);
        chk("set_latency", lat, 4);
        chk("set_rdata", rdv, 32'h88);
        chk("set_wdata", last_wd, 32'h8B);
        chk("set_we_cycles", we_cnt - w0, 1);

        drive(1, OP_CLEAR, 12'h300, 32'h80, lat, rdv, rdc);
        drop(1);
        chk("clr_latency", lat, 4);
        chk("clr_rdata", rdv, 32'h8B);
        chk("clr_wdata", last_wd, 32'h0B);

        w0 = we_cnt;
        drive(1, OP_SET, 12'h300, 32'h0, lat, rdv, rdc);
        drop(1);
        chk("set0_latency", lat, 3);
        chk("set0_rdata", rdv, 32'h0B);
        chk("set0_no_we", we_cnt - w0, 0);

        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        ack_q.delete();
        overlap = 0;
        fork
            begin : core_side
                int          l;
                logic [31:0] a, b;
                for (int k = 0; k < 4; k++)
                    drive(0, OP_WRITE, 12'h340, 32'(k + 1), l, a, b);
                drop(0);
            end
            begin : dbg_side
                int          l;
                logic [31:0] a, b;
                for (int k = 0; k < 4; k++)
                    drive(1, OP_SET, 12'h301, 32'(1 << k), l, a, b);
                drop(1);
            end
        join
        chk("rr_count", ack_q.size(), 8);
        for (int i = 0; i < 8 && i < ack_q.size(); i++)
            chk("rr_order", ack_q[i], i % 2);
        chk("ack_overlap", overlap, 0);

        repeat (3) @(posedge clk);
        #1;
        core_if.req = 1; core_if.op = OP_WRITE; core_if.addr = 12'h305; core_if.wdata = 32'h55;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        core_if.req = 0;
        @(negedge clk);
        chk("abort_we_in_write", 32'(csr_we), 1);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("abort_we_dropped", 32'(csr_we), 0);
        chk("abort_no_ack", 32'(core_if.ack), 0);
        chk("abort_idle", 32'(busy), 0);
        @(posedge clk); #1;
        w0 = we_cnt;
        drive(0, OP_WRITE, 12'h305, 32'h66, lat, rdv, rdc);
        drop(0);
        chk("reissue_latency", lat, 4);
        chk("reissue_we_cycles", we_cnt - w0, 1);
        chk("reissue_wdata", last_wd, 32'h66);

        fork
            random_req(0, 60);
            random_req(1, 60);
        join
        repeat (6) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_arbiter.md
# csr_arbiter

Shares the single CSR register-file port between two requesters: the core execute stage and the debug module. Each requester issues one CSR operation at a time over a req/ack handshake. The arbiter grants the port round-robin and sequences each operation as a read, optionally followed by a write for read-modify-write ops. It sits between the requesters and `csr_reg`, drives that block's address, write-enable and write-data inputs, and samples its combinational `data_o`.

## Interface
Parameters:
- ADDR_W, 32, width of the CSR-port address (`MemAddrBus`)
- DATA_W, 32, CSR data width (`RegBus`)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- core_req_i  in  1  core request, held until core_ack_o
- core_op_i  in  2  op: 00 READ, 01 WRITE, 10 SET, 11 CLEAR
- core_addr_i  in  12  CSR address
- core_wdata_i  in  DATA_W  write value / bit mask
- core_ack_o  out  1  one-cycle completion pulse
- core_rdata_o  out  DATA_W  old CSR value, valid from ack until this requester's next ack
- dbg_req_i, dbg_op_i, dbg_addr_i, dbg_wdata_i, dbg_ack_o, dbg_rdata_o  same as the core_* ports, for the debug requester
- csr_raddr_o  out  ADDR_W  read address to csr_reg
- csr_rdata_i  in  DATA_W  csr_reg read data (combinational)
- csr_we_o  out  1  write enable to csr_reg
- csr_waddr_o  out  ADDR_W  write address
- csr_wdata_o  out  DATA_W  write data
- busy_o  out  1  high whenever the FSM is not in IDLE

## Operation
FSM states:
- **IDLE:** if any req_i is high, grant one requester and latch its op, addr and wdata, plus the grant id. Go to READ.
- **READ:** csr_raddr_o = latched addr. Capture csr_rdata_i into old_q.
  - Compute new value: WRITE → wdata; SET → old | wdata; CLEAR → old & ~wdata.
  - Go to WRITE if op = WRITE, or if op ∈ {SET, CLEAR} with wdata ≠ 0.
  - Otherwise go to ACK. SET/CLEAR with wdata = 0 never write.
- **WRITE:** csr_we_o = 1; csr_waddr_o = addr; csr_wdata_o = new value. Go to ACK.
- **ACK:** assert the granted requester's ack_o for one cycle. Load that requester's rdata_o register from old_q. Go to IDLE.

Arbitration:
- Round-robin via last_grant_q, which is updated on each grant.
- When both requesters are high in IDLE, the one that was not last granted wins.
- A lone requester always wins.
- last_grant_q resets to debug, so the core wins the first tie.

Address handling:
- 12-bit addresses are zero-extended to ADDR_W.
- csr_raddr_o and csr_waddr_o hold the latched address outside READ/WRITE; they are 0 after reset.

Handshake rules:
- A requester keeps req, op, addr and wdata stable until it sees ack.
- It drops req in the cycle after ack, or immediately re-raises it for a new op.
- req sampled in the ACK cycle is ignored; only IDLE arbitrates.

Reset values:
- state = IDLE
- all ack_o = 0, csr_we_o = 0, busy_o = 0
- rdata_o, old_q, address and data outputs = 0

Reset mid-operation:
- State returns to IDLE and csr_we_o drops in the same edge.
- No ack is issued; the aborted requester re-requests.

## Timing
- Cycle 0: req high, IDLE, grant.
- Cycle 1: READ.
- READ op: ack in cycle 2, so 3-cycle latency from req to ack.
- WRITE/SET/CLEAR op: we in cycle 2, ack in cycle 3, so 4-cycle latency.
- Back-to-back ops: the next grant is no earlier than the cycle after ACK. Steady state is one op per 3 cycles (read) or 4 cycles (write).
- csr_we_o is high for exactly one cycle per write, and only in WRITE.
- rdata_o changes only on the ack edge.

## Structure
- Op encodings (CsrOpRead/Write/Set/Clear) and FSM state encodings go in `defines.v` as `define constants alongside `RegBus`/`MemAddrBus`.
- One natural sub-module: `csr_rr_arb`, a two-way round-robin grant with last-grant register.
- Everything else lives in a single always-block FSM.

## Test plan
- **Reset:** rst high for 3 cycles with core_req_i = 1 → no ack, csr_we_o = 0, busy_o = 0, all rdata_o = 0.
- **Core READ of 0xC00 against a live csr_reg:**
  - core_ack_o pulses exactly 3 cycles after req.
  - core_rdata_o equals the cycle counter sampled in READ.
  - csr_we_o is never asserted.
- **Debug WRITE to 0x300, value 0x0000_0088, against a bench memory model:**
  - csr_we_o high for 1 cycle, waddr = 0x300, wdata = 0x88.
  - dbg_ack_o pulses at cycle 3; dbg_rdata_o = previous contents.
- **SET and CLEAR on 0x300 preloaded with 0x88:**
  - SET mask 0x3 → wdata 0x8B.
  - CLEAR mask 0x80 → wdata 0x0B.
  - SET mask 0 → no we, ack at cycle 2.
- **Simultaneous requests from reset, both held for 4 ops each:**
  - Grants alternate core, debug, core, debug.
  - No ack overlap; each requester's rdata stays stable between its own acks.
- **rst asserted in the WRITE cycle:**
  - csr_we_o low the next cycle; no ack.
  - Re-issued request completes normally with 4-cycle latency.
